// File: rtl/stm32_bus_master.sv
// Host-side initiator for the 8-bit DATA_BUS / DATA_SYNC command link: one framed command byte, then N bytes.
// Define STM32_BUS_LOOPBACK_CHECK_EN to turn cmd=0 into a one-byte loopback self-check counted in lb_err_count.
module stm32_bus_master #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic             rd,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             bus_clk,
  output logic             DATA_SYNC,
  inout  wire  [7:0]       DATA_BUS,
  output logic [7:0]       lb_err_count
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SYNC, WDATA, TURN, RDATA, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [7:0]       cmd_q, cmd_d, wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic             bus_clk_q, bus_clk_d, rd_q, rd_d, lb_q, lb_d;
  logic             have_q, have_d, rd_valid_q, rd_valid_d;
  logic             tc, bus_oe, lb_start;

  assign tc      = (div_q == DIV_TC);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bus_clk_d  = bus_clk_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    rd_d       = rd_q;
    lb_d       = lb_q;
    wdata_d    = wdata_q;
    have_d     = have_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ready   = 1'b0;
    if (state_q != IDLE && state_q != DONE) div_d = tc ? '0 : div_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        bus_clk_d = 1'b0;
        div_d     = '0;
        cnt_d     = '0;
        have_d    = 1'b0;
        if (start) begin
          cmd_d   = cmd;
          len_d   = lb_start ? LEN_W'(1) : len;
          rd_d    = rd & ~lb_start;
          lb_d    = lb_start;
          state_d = SYNC;
        end
      end
      SYNC: if (tc) begin
        bus_clk_d = ~bus_clk_q;
        if (bus_clk_q) begin
          if (len_q == '0)  state_d = DONE;
          else if (rd_q)    state_d = TURN;
          else              state_d = WDATA;
        end
      end
      WDATA: begin
        if (!bus_clk_q && !have_q && wr_valid) begin
          wr_ready = 1'b1;
          wdata_d  = wr_data;
          have_d   = 1'b1;
        end
        // A byte must already sit on the bus before the edge, otherwise the low phase is stretched
        if (tc) begin
          if (!bus_clk_q) begin
            if (have_q) bus_clk_d = 1'b1;
            else        div_d     = div_q;
          end else begin
            bus_clk_d = 1'b0;
            have_d    = 1'b0;
            cnt_d     = cnt_inc;
            if (cnt_inc == len_q) state_d = lb_q ? TURN : DONE;
          end
        end
      end
      TURN: begin
        cnt_d = '0;
        if (tc) begin
          bus_clk_d = ~bus_clk_q;
          if (bus_clk_q) state_d = RDATA;
        end
      end
      RDATA: if (tc) begin
        if (!bus_clk_q) begin
          rd_data_d  = DATA_BUS;
          rd_valid_d = 1'b1;
          cnt_d      = cnt_inc;
          if (cnt_inc == len_q) state_d   = DONE;
          else                  bus_clk_d = 1'b1;
        end else begin
          bus_clk_d = 1'b0;
        end
      end
      DONE: begin
        bus_clk_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bus_clk_q  <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      lb_q       <= 1'b0;
      have_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bus_clk_q  <= bus_clk_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      lb_q       <= lb_d;
      have_q     <= have_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk_in) begin
    cmd_q   <= cmd_d;
    len_q   <= len_d;
    wdata_q <= wdata_d;
  end

`ifdef STM32_BUS_LOOPBACK_CHECK_EN
  logic [7:0] err_q;
  assign lb_start = (cmd == 8'h00);
  always_ff @(posedge clk_in) begin
    if (reset) err_q <= '0;
    else if (state_q == RDATA && tc && !bus_clk_q && lb_q && DATA_BUS != wdata_q && err_q != 8'hFF)
      err_q <= err_q + 1'b1;
  end
  assign lb_err_count = err_q;
`else
  assign lb_start     = 1'b0;
  assign lb_err_count = 8'h00;
`endif

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign DATA_SYNC = (state_q == SYNC);
  assign bus_oe    = (state_q == SYNC) || (state_q == WDATA);
  assign DATA_BUS  = bus_oe ? ((state_q == SYNC) ? cmd_q : wdata_q) : 'z;
  assign bus_clk   = bus_clk_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_stm32_bus_master.sv
// Scoreboard bench for stm32_bus_master: expected bus edges, read bytes and completions are queued at issue
// time and checked by a negedge monitor that also plays the responder.
module tb_stm32_bus_master;
  localparam int CLK_DIV = 2;

  typedef struct packed {
    logic       sync;
    logic [7:0] data;
    logic       chk;
  } edge_t;

  logic       clk_in = 1'b0, reset, start, rd, wr_valid;
  logic [7:0] cmd, len, wr_data;
  logic       busy, done, wr_ready, rd_valid, bus_clk, DATA_SYNC;
  logic [7:0] rd_data, lb_err_count;
  wire  [7:0] DATA_BUS;
  logic       resp_oe;
  logic [7:0] resp_data;

  assign DATA_BUS = resp_oe ? resp_data : 'z;

  stm32_bus_master #(.CLK_DIV(CLK_DIV), .LEN_W(8)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .cmd(cmd), .len(len), .rd(rd),
    .busy(busy), .done(done), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .bus_clk(bus_clk), .DATA_SYNC(DATA_SYNC),
    .DATA_BUS(DATA_BUS), .lb_err_count(lb_err_count)
  );

  always #5 clk_in = ~clk_in;

  int         tests = 0, fails = 0;
  edge_t      exp_edge_q[$];
  logic [7:0] exp_rd_q[$], wr_src_q[$], resp_src_q[$];
  int         exp_done_q[$];
  logic [7:0] pay [0:15];
  logic [7:0] lb_echo;
  bit         mute = 1'b1, took = 1'b0, bclk_prev = 1'b0;
  int         cur_mode = 0, edge_n = 0, wr_ready_n = 0, wr_pop_n = 0, done_seen = 0;
  int         stall_idx = 0, stall_left = 0, low_run = 0, max_low = 0, last_max_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush();
    mute = 1'b1;
    exp_edge_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
    wr_src_q.delete(); resp_src_q.delete();
    wr_ready_n = 0; edge_n = 0; low_run = 0; max_low = 0; stall_left = 0; resp_oe = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  d0;
    bit  ok;
    d0 = done_seen;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_in); #1;
      if (done_seen != d0) begin ok = 1'b1; break; end
    end
    check("done_timeout", 32'(ok), 1);
    if (!ok) begin
      flush();
      reset = 1'b1;
      @(posedge clk_in); #1;
      reset = 1'b0;
      mute = 1'b0;
    end
  endtask

  // mode: 0 write, 1 read, 2 loopback (echo byte in lb_echo)
  task automatic issue(input logic [7:0] c, input int n, input int mode, input bit poke);
    edge_t e;
    wr_pop_n = 0;
    e.sync = 1'b1; e.data = c; e.chk = 1'b1;
    exp_edge_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.sync = 1'b0; e.data = pay[i]; e.chk = (mode != 1);
      exp_edge_q.push_back(e);
      if (mode == 1) begin
        resp_src_q.push_back(pay[i]);
        exp_rd_q.push_back(pay[i]);
      end else begin
        wr_src_q.push_back(pay[i]);
      end
    end
    if (mode == 2) begin
      e.sync = 1'b0; e.data = 8'h00; e.chk = 1'b0;
      exp_edge_q.push_back(e);
      resp_src_q.push_back(lb_echo);
      exp_rd_q.push_back(lb_echo);
    end
    exp_done_q.push_back((mode == 1) ? 0 : n);
    cur_mode = mode;
    cmd = c; len = 8'(n); rd = (mode == 1); start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    if (poke) begin
      cmd = 8'h77; len = 8'd3; rd = 1'b0; start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
    end
    wait_done(8 * CLK_DIV * (n + 3) + 100);
  endtask

  // Monitor and responder: everything sampled on the falling clk_in edge
  initial begin
    edge_t e;
    logic [7:0] x;
    resp_oe = 1'b0; resp_data = 8'h00;
    forever begin
      @(negedge clk_in);
      took = wr_ready;
      if (!mute) begin
        if (bus_clk && !bclk_prev) begin
          edge_n++;
          if (exp_edge_q.size() == 0) begin
            check("edge_extra", 32'(edge_n), 0);
          end else begin
            e = exp_edge_q.pop_front();
            check("edge_sync", 32'(DATA_SYNC), 32'(e.sync));
            if (e.chk) check("edge_data", 32'(DATA_BUS), 32'(e.data));
          end
          if (((cur_mode == 1 && edge_n >= 2) || (cur_mode == 2 && edge_n == 3)) && resp_src_q.size() > 0) begin
            resp_oe = 1'b1;
            resp_data = resp_src_q.pop_front();
          end
        end
        if (bus_clk) low_run = 0;
        else if (busy) begin
          low_run++;
          if (low_run > max_low) max_low = low_run;
        end
        if (wr_ready) wr_ready_n++;
        if (rd_valid) begin
          if (exp_rd_q.size() == 0) check("rd_extra", 32'(rd_data), 32'hFFFF);
          else begin
            x = exp_rd_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(x));
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) check("done_extra", 32'(done), 0);
          else check("wr_ready_count", 32'(wr_ready_n), 32'(exp_done_q.pop_front()));
          check("edges_missing", 32'(exp_edge_q.size()), 0);
          check("rd_missing", 32'(exp_rd_q.size()), 0);
          check("busy_at_done", 32'(busy), 0);
          last_max_low = max_low;
          wr_ready_n = 0; edge_n = 0; low_run = 0; max_low = 0;
          resp_oe = 1'b0;
          done_seen++;
        end
      end
      bclk_prev = bus_clk;
    end
  end

  // Write-stream source; optional stall of wr_valid in the low phase of byte stall_idx
  initial begin
    wr_valid = 1'b0; wr_data = 8'h00;
    forever begin
      @(posedge clk_in); #2;
      if (took && wr_src_q.size() > 0) begin
        void'(wr_src_q.pop_front());
        wr_pop_n++;
      end
      if (wr_src_q.size() > 0 && wr_pop_n == stall_idx && stall_left > 0 && !bus_clk && busy) begin
        wr_valid = 1'b0;
        stall_left--;
      end else begin
        wr_valid = (wr_src_q.size() > 0);
        wr_data  = (wr_src_q.size() > 0) ? wr_src_q[0] : 8'h00;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 8'h00; len = 8'h00; rd = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bus_clk", 32'(bus_clk), 0);
    check("rst_sync", 32'(DATA_SYNC), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_lb_err", 32'(lb_err_count), 0);
    @(posedge clk_in); #1;
    reset = 1'b0; mute = 1'b0;

    for (int i = 0; i < 15; i++) pay[i] = 8'(i + 1);
    issue(8'h01, 15, 0, 1'b0);

    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    stall_idx = 2; stall_left = 10;
    issue(8'h03, 4, 0, 1'b0);
    check("stretch_min", 32'(last_max_low >= 11), 1);
    check("stretch_max", 32'(last_max_low <= 13), 1);
    stall_left = 0;

    for (int i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + i);
    issue(8'h04, 8, 1, 1'b0);

    issue(8'h05, 0, 0, 1'b1);
    issue(8'h06, 0, 1, 1'b1);

    // Reset in the middle of a four-byte write, with byte 2 pending
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hC0 + i);
    mute = 1'b1; wr_pop_n = 0;
    for (int i = 0; i < 4; i++) wr_src_q.push_back(pay[i]);
    cmd = 8'h02; len = 8'd4; rd = 1'b0; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && wr_pop_n < 2; k++) begin
      @(posedge clk_in); #1;
    end
    check("rst_mid_reached", 32'(wr_pop_n >= 2), 1);
    flush();
    reset = 1'b1; resp_oe = 1'b1; resp_data = 8'h3C;
    @(posedge clk_in);
    @(negedge clk_in);
    check("mid_rst_bus_clk", 32'(bus_clk), 0);
    check("mid_rst_sync", 32'(DATA_SYNC), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_bus_z", 32'(DATA_BUS), 32'h3C);
    @(posedge clk_in); #1;
    reset = 1'b0; resp_oe = 1'b0;
    @(negedge clk_in);
    check("mid_rst_no_done", 32'(done), 0);
    check("mid_rst_idle", 32'(busy), 0);
    @(posedge clk_in); #1;
    mute = 1'b0;

    for (int t = 0; t < 25; t++) begin
      int         n;
      int         m;
      logic [7:0] c;
      n = $urandom_range(0, 12);
      m = $urandom_range(0, 1);
      c = 8'($urandom_range(1, 255));
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      stall_idx  = $urandom_range(0, 12);
      stall_left = (m == 0) ? $urandom_range(0, 5) : 0;
      issue(c, n, m, 1'b0);
      stall_left = 0;
    end

`ifdef STM32_BUS_LOOPBACK_CHECK_EN
    pay[0] = 8'h5A; lb_echo = 8'h5A;
    issue(8'h00, 1, 2, 1'b0);
    check("lb_err_after_match", 32'(lb_err_count), 0);
    pay[0] = 8'hFF; lb_echo = 8'h00;
    issue(8'h00, 1, 2, 1'b0);
    check("lb_err_after_mismatch", 32'(lb_err_count), 1);
`endif

    repeat (4) @(posedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
